instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction decoder/control unit. Owns the PC,
//  issues word reads to instruction memory (valid/ready request, separate response),
//  buffers returned words in a small FIFO and presents instr/Op/Funct/PC downstream.
//  Handles taken-branch redirect: flushes buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset (word aligned)
//  FIFO_DEPTH  2              instruction buffer entries (>=2, power of 2)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  imem_req       out  1   read request valid
//  imem_addr      out  32  read byte address (bits [1:0] always 0)
//  imem_ready     in   1   memory accepts request this cycle
//  imem_rvalid    in   1   read data valid (>=1 cycle after acceptance, in order)
//  imem_rdata     in   32  read data
//  branch_taken   in   1   redirect pulse from branch resolution
//  branch_target  in   32  redirect address; bits [1:0] ignored (forced 00)
//  instr_valid    out  1   instr/Op/Funct/instr_pc valid
//  instr_ready    in   1   downstream accepts (0 = stall)
//  instr          out  32  instruction word
//  instr_pc       out  32  address of instr
//  Op             out  6   instr[31:26]
//  Funct          out  6   instr[5:0]
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, state=FETCH, FIFO empty, outstanding=0;
//   imem_req=0, instr_valid=0, instr/instr_pc/Op/Funct=0. imem_req may rise 1st cycle after release.
//  States: FETCH (no outstanding or response pending normally), WAIT_RESP (1 outstanding),
//   DISCARD (1 outstanding belonging to a flushed path). Max 1 request outstanding.
//  Issue: imem_req=1, imem_addr=pc_q when (state==FETCH or (WAIT_RESP and imem_rvalid))
//   and fifo_count+outstanding < FIFO_DEPTH and !branch_taken. No comb path instr_ready->imem_req.
//  Accept (imem_req&&imem_ready): pc_q<=pc_q+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); ->WAIT_RESP.
//   While imem_ready=0, imem_req/imem_addr held stable.
//  Response in WAIT_RESP: push {imem_rdata, pc_of_request} into FIFO; ->FETCH unless new
//   request accepted same cycle (stays WAIT_RESP). Latency: rvalid cycle N -> instr_valid N+1.
//  imem_rvalid with outstanding=0 is ignored.
//  Output: instr_valid=!fifo_empty; instr/instr_pc from head; Op/Funct sliced from instr;
//   all data outputs 0 when instr_valid=0. Pop on instr_valid&&instr_ready. Push to full FIFO
//   cannot occur (issue bound); simultaneous push/pop keeps count.
//  Redirect (branch_taken=1, priority over everything): FIFO flushed (instr_valid=0 next cycle),
//   pc_q<={branch_target[31:2],2'b00}, imem_req=0 this cycle. If outstanding and no rvalid
//   this cycle ->DISCARD; if rvalid same cycle, data dropped ->FETCH. Pop in same cycle is void.
//  DISCARD: imem_req=0; on imem_rvalid drop data ->FETCH. Redirect in DISCARD updates pc_q only.
//  Reset mid-operation: state cleared immediately; in-flight response after release ignored.
// STRUCTURE
//  mips_pkg: INSTR_W=32, OP_MSB/LSB=31/26, FUNCT_MSB/LSB=5/0, PC_INC=4, fetch state encodings
//   (FETCH/WAIT_RESP/DISCARD), default RESET_PC.
//  Sub-module ifu_fifo: sync FIFO, WIDTH=64 ({pc,instr}), DEPTH=FIFO_DEPTH, push/pop/flush,
//   count/empty/full, async active-low reset. Top holds PC, FSM, issue logic, field slicing.
// TESTING
//  1 Reset release, imem_ready=1, rvalid 1 cycle after accept, instr_ready=1 -> imem_addr
//    0,4,8,... one per cycle; first instr_valid 2 cycles after first accept; instr_pc=0,4,8.
//  2 instr_ready=0 from start -> FIFO holds 2 entries (PC 0,4), imem_req=0 afterwards;
//    release -> 0,4 drained in order, fetch resumes at 8, no loss/duplicate.
//  3 branch_taken target 0x43 while fetch of 0x8 outstanding -> 0x8 data dropped, next
//    imem_addr=0x40, instr_valid=0 until 0x40 data arrives, then instr_pc=0x40.
//  4 branch_taken same cycle as imem_rvalid -> data dropped, state FETCH, next req addr=target.
//  5 imem_ready=0 for 3 cycles -> req/addr stable; rdata 0x8C82_0004 -> Op=6'b100011,
//    Funct=6'b000100; pc_q=0xFFFF_FFFC fetch -> next imem_addr=0x0.
//  6 rst_n low mid-WAIT_RESP -> outputs 0 immediately; stray rvalid after release ignored;
//    first request at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared constants and fetch-state encoding for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          OP_MSB           = 31;
  localparam int          OP_LSB           = 26;
  localparam int          FUNCT_MSB        = 5;
  localparam int          FUNCT_LSB        = 0;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_RESP = 2'd1,
    DISCARD   = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
//  Module   : ifu_fifo
//  Brief    : Small synchronous FIFO holding {pc, instr} pairs; flush wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= push_data;
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fetch stage: PC, single-outstanding imem reads, buffer, redirect.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic [5:0]         Op,
  output logic [5:0]         Funct
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_req_pc, w_req_pc_nxt;
  logic          r_active;

  logic          w_push, w_pop, w_flush;
  logic [63:0]   w_head;
  logic [CW-1:0] w_count, w_inflight;
  logic          w_empty, w_full;
  logic          w_outstanding, w_issue, w_accept;
  logic [31:0]   w_target;

  ifu_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({r_req_pc, imem_rdata}),
    .pop       (w_pop),
    .flush     (w_flush),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign w_outstanding = (r_state != FETCH);
  assign w_inflight    = w_count + {{(CW-1){1'b0}}, w_outstanding};
  assign w_target      = branch_target & ~32'h3;

  // Issue sees only registered occupancy, so a downstream pop never gates the request.
  assign w_issue  = r_active && !branch_taken &&
                    (r_state == FETCH || (r_state == WAIT_RESP && imem_rvalid)) &&
                    (w_inflight < CW'(FIFO_DEPTH));
  assign w_accept = w_issue && imem_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_pop        = !w_empty && instr_ready && !branch_taken;
    if (branch_taken) begin
      w_flush  = 1'b1;
      w_pc_nxt = w_target;
      if (w_outstanding) w_state_nxt = imem_rvalid ? FETCH : DISCARD;
      else               w_state_nxt = FETCH;
    end else begin
      if (imem_rvalid && r_state == WAIT_RESP) begin
        w_push      = !w_full;
        w_state_nxt = FETCH;
      end
      if (imem_rvalid && r_state == DISCARD) w_state_nxt = FETCH;
      if (w_accept) begin
        w_pc_nxt     = r_pc + PC_INC;
        w_req_pc_nxt = r_pc;
        w_state_nxt  = WAIT_RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_active <= 1'b1;
    end
  end

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = instr_valid ? w_head[31:0]  : '0;
  assign instr_pc    = instr_valid ? w_head[63:32] : '0;
  assign Op          = instr[OP_MSB:OP_LSB];
  assign Funct       = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

`default_nettype wire
